// File: rtl/onehot_index_decoder.sv
// onehot_index_decoder: registered one-hot to binary index converter with a
// valid/ready handshake, illegal-code and end-of-round flags, and a round counter.
// Optional sequence checker enabled by defining ONEHOT_INDEX_DECODER_SEQ_CHECK_EN;
// without it seq_err_o is tied low and no checker state exists.
module onehot_index_decoder #(
  parameter  int width_p        = 8,
  parameter  int rounds_width_p = 8,
  localparam int iw             = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      clear_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [width_p-1:0]        onehot_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [iw-1:0]             index_o,
  output logic                      illegal_o,
  output logic                      wrap_o,
  output logic [rounds_width_p-1:0] rounds_o,
  output logic                      seq_err_o
);

  localparam int cw = $clog2(width_p + 1);

  logic                      accept;
  logic [iw-1:0]             index_p0;
  logic [cw-1:0]             popcnt_p0;
  logic                      found_p0;
  logic                      illegal_p0;
  logic                      wrap_p0;

  logic                      vld_p1;
  logic [iw-1:0]             index_p1;
  logic                      illegal_p1;
  logic                      wrap_p1;
  logic [rounds_width_p-1:0] rounds_r;

  // A single output slot: space exists when it is empty or draining this cycle.
  assign ready_o = ~vld_p1 | ready_i;
  assign accept  = valid_i & ready_o;

  // Stage p0: lowest-set-bit encode and population count of the incoming code.
  always_comb begin
    index_p0  = '0;
    popcnt_p0 = '0;
    found_p0  = 1'b0;
    for (int i = 0; i < width_p; i++) begin
      if (onehot_i[i]) begin
        if (!found_p0) begin
          index_p0 = iw'(i);
          found_p0 = 1'b1;
        end
        popcnt_p0 = popcnt_p0 + cw'(1);
      end
    end
  end

  assign illegal_p0 = (popcnt_p0 != cw'(1));
  assign wrap_p0    = ~illegal_p0 & onehot_i[width_p-1];

  // Stage p1: output register loads on accept, empties when drained without refill.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vld_p1     <= 1'b0;
      index_p1   <= '0;
      illegal_p1 <= 1'b0;
      wrap_p1    <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      index_p1   <= index_p0;
      illegal_p1 <= illegal_p0;
      wrap_p1    <= wrap_p0;
    end else if (ready_i) begin
      vld_p1     <= 1'b0;
    end
  end

  // Round counter: counts accepted legal MSB-hot codes; clear has priority.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rounds_r <= '0;
    end else if (clear_i) begin
      rounds_r <= '0;
    end else if (accept && wrap_p0) begin
      rounds_r <= rounds_r + rounds_width_p'(1);
    end
  end

  assign valid_o   = vld_p1;
  assign index_o   = index_p1;
  assign illegal_o = illegal_p1;
  assign wrap_o    = wrap_p1;
  assign rounds_o  = rounds_r;

`ifdef ONEHOT_INDEX_DECODER_SEQ_CHECK_EN
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } seq_state_t;

  seq_state_t         state_r;
  seq_state_t         state_nxt;
  logic [width_p-1:0] prev_r;
  logic [width_p-1:0] expect_code;
  logic               seq_match;

  // Next code the counter should produce: shift left, MSB rolls back to bit 0.
  assign expect_code = prev_r[width_p-1] ? width_p'(1) : (prev_r << 1);
  assign seq_match   = ~illegal_p0 & (onehot_i == expect_code);

  // Checker state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= SYNC;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Checker next state: clear overrides any same-cycle error.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      SYNC:    if (accept && !illegal_p0) state_nxt = TRACK;
      TRACK:   if (accept && !seq_match)  state_nxt = FAULT;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = SYNC;
    endcase
    if (clear_i) begin
      state_nxt = SYNC;
    end
  end

  // Last accepted in-order code; only meaningful once the checker leaves SYNC.
  always_ff @(posedge clk_i) begin
    if (accept && ((state_r == SYNC && !illegal_p0) || (state_r == TRACK && seq_match))) begin
      prev_r <= onehot_i;
    end
  end

  // Checker output: error is sticky for as long as the FSM sits in FAULT.
  always_comb begin
    seq_err_o = (state_r == FAULT);
  end
`else
  assign seq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_index_decoder.sv
// Directed bench for onehot_index_decoder (width_p=4, rounds_width_p=3).
// Sequence-check expectations follow ONEHOT_INDEX_DECODER_SEQ_CHECK_EN.
module tb_onehot_index_decoder;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       clear_i;
  logic       valid_i;
  logic       ready_o;
  logic [3:0] onehot_i;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] index_o;
  logic       illegal_o;
  logic       wrap_o;
  logic [2:0] rounds_o;
  logic       seq_err_o;

  int total = 0;
  int bad   = 0;

`ifdef ONEHOT_INDEX_DECODER_SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  onehot_index_decoder #(.width_p(4), .rounds_width_p(3)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (clear_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .onehot_i (onehot_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .index_o  (index_o),
    .illegal_o(illegal_o),
    .wrap_o   (wrap_o),
    .rounds_o (rounds_o),
    .seq_err_o(seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [3:0] code);
    valid_i  = 1'b1;
    onehot_i = code;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [1:0] idx, input logic ill, input logic wrp);
    check({tag, ".valid"}, 32'(valid_o), 32'd1);
    check({tag, ".index"}, 32'(index_o), 32'(idx));
    check({tag, ".illegal"}, 32'(illegal_o), 32'(ill));
    check({tag, ".wrap"}, 32'(wrap_o), 32'(wrp));
  endtask

  initial begin
    reset_ni = 1'b0;
    clear_i  = 1'b0;
    valid_i  = 1'b0;
    onehot_i = 4'b0000;
    ready_i  = 1'b1;
    tick();
    tick();
    reset_ni = 1'b1;
    tick();

    // Reset state
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.index", 32'(index_o), 32'd0);
    check("rst.illegal", 32'(illegal_o), 32'd0);
    check("rst.wrap", 32'(wrap_o), 32'd0);
    check("rst.rounds", 32'(rounds_o), 32'd0);
    check("rst.seq_err", 32'(seq_err_o), 32'd0);
    check("rst.ready", 32'(ready_o), 32'd1);

    // Streaming with ready_i=1
    send(4'b0001); expect_out("s0", 2'd0, 1'b0, 1'b0);
    send(4'b0010); expect_out("s1", 2'd1, 1'b0, 1'b0);
    send(4'b0100); expect_out("s2", 2'd2, 1'b0, 1'b0);
    send(4'b1000); expect_out("s3", 2'd3, 1'b0, 1'b1);
    check("s3.rounds", 32'(rounds_o), 32'd1);
    send(4'b0001); expect_out("s4", 2'd0, 1'b0, 1'b0);
    check("s4.rounds", 32'(rounds_o), 32'd1);
    valid_i = 1'b0;
    tick();
    check("drain.valid", 32'(valid_o), 32'd0);
    check("drain.index_hold", 32'(index_o), 32'd0);

    // Backpressure: hold for three cycles, then release
    ready_i = 1'b0;
    send(4'b0010); expect_out("bp0", 2'd1, 1'b0, 1'b0);
    onehot_i = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      check("bp.ready", 32'(ready_o), 32'd0);
      tick();
      expect_out("bp.hold", 2'd1, 1'b0, 1'b0);
    end
    ready_i = 1'b1;
    #1;
    check("bp.release_ready", 32'(ready_o), 32'd1);
    tick();
    expect_out("bp1", 2'd2, 1'b0, 1'b0);
    valid_i = 1'b0;
    tick();
    check("bp.drain", 32'(valid_o), 32'd0);
    check("bp.index_hold", 32'(index_o), 32'd2);

    // Illegal codes
    send(4'b0000); expect_out("ill0", 2'd0, 1'b1, 1'b0);
    send(4'b0110); expect_out("ill1", 2'd1, 1'b1, 1'b0);
    send(4'b1100); expect_out("ill2", 2'd2, 1'b1, 1'b0);
    check("ill.rounds", 32'(rounds_o), 32'd1);
    send(4'b1000); expect_out("ill3", 2'd3, 1'b0, 1'b1);
    check("ill3.rounds", 32'(rounds_o), 32'd2);

    // Round counter wraps after 8 full rounds
    valid_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr.rounds", 32'(rounds_o), 32'd0);
    check("clr.out_hold", 32'(index_o), 32'd3);
    for (int r = 0; r < 8; r++) begin
      send(4'b0001);
      send(4'b0010);
      send(4'b0100);
      send(4'b1000);
      check("round.count", 32'(rounds_o), 32'((r + 1) % 8));
    end
    send(4'b0001); send(4'b0010); send(4'b0100); send(4'b1000);
    check("pre_clr.rounds", 32'(rounds_o), 32'd1);
    send(4'b0001); send(4'b0010); send(4'b0100);
    clear_i = 1'b1;
    send(4'b1000);
    clear_i = 1'b0;
    check("clr_wins.rounds", 32'(rounds_o), 32'd0);
    check("clr_wins.wrap", 32'(wrap_o), 32'd1);

    // Sequence checking
    valid_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("seq.clear0", 32'(seq_err_o), 32'd0);
    send(4'b0001);
    send(4'b0010);
    check("seq.inorder", 32'(seq_err_o), 32'd0);
    send(4'b1000); expect_out("seq.skip", 2'd3, 1'b0, 1'b1);
    check("seq.err", 32'(seq_err_o), 32'(SEQ_ON));
    valid_i = 1'b0;
    tick();
    check("seq.sticky", 32'(seq_err_o), 32'(SEQ_ON));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("seq.cleared", 32'(seq_err_o), 32'd0);
    send(4'b0100);
    send(4'b1000);
    check("seq.resync", 32'(seq_err_o), 32'd0);
    send(4'b0001);
    check("seq.rollover", 32'(seq_err_o), 32'd0);
    send(4'b0000);
    check("seq.illegal_err", 32'(seq_err_o), 32'(SEQ_ON));

    // Asynchronous reset mid-stream
    send(4'b1000);
    reset_ni = 1'b0;
    #1;
    check("arst.valid", 32'(valid_o), 32'd0);
    check("arst.index", 32'(index_o), 32'd0);
    check("arst.wrap", 32'(wrap_o), 32'd0);
    check("arst.illegal", 32'(illegal_o), 32'd0);
    check("arst.rounds", 32'(rounds_o), 32'd0);
    check("arst.seq_err", 32'(seq_err_o), 32'd0);
    check("arst.ready", 32'(ready_o), 32'd1);
    valid_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
